sap_ctrl_seq: RTL and testbench
===============================

# sap_ctrl_seq

Controller/sequencer that drives the `Inen`/`Oen` strobes of the 8-bit bus registers: program counter, memory address register (MAR), RAM, instruction register (IR), accumulator A, B register and the output register. It steps a six-phase T-state ring (fetch T1–T3, execute T4–T6) and decodes the IR opcode into a one-cycle control word per phase. It sits directly upstream of every Inen/Oen register on the shared 8-bit bus.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock shared with all bus registers.
- `clr`  in  1  synchronous active-low reset.
- `run`  in  1  1 = advance one T-state per clock; 0 = freeze.
- `opcode`  in  4  IR upper nibble.
- `tstate`  out  6  one-hot phase, bit0 = T1.
- `halt`  out  1  HLT executed; sticky until reset.
- `pc_inc`, `pc_oen`, `mar_inen`, `ram_oen`, `ir_inen`, `ir_oen`, `a_inen`, `a_oen`, `b_inen`, `alu_oen`, `alu_sub`, `out_inen`  out  1 each  control word.

## Operation
- States: T1..T6 (one-hot ring) plus HALT.
- Ring order: T1→T2→…→T6→T1. Advances only when `run`=1 and not HALT.
- Fetch, identical for all opcodes:
  - T1: `pc_oen`, `mar_inen`.
  - T2: `pc_inc`.
  - T3: `ram_oen`, `ir_inen`.
- Execute; opcode read live in T4–T6 (IR loads on the T3→T4 edge):
  - LDA 0000: T4 `ir_oen`,`mar_inen`; T5 `ram_oen`,`a_inen`; T6 none.
  - ADD 0001: T4 `ir_oen`,`mar_inen`; T5 `ram_oen`,`b_inen`; T6 `alu_oen`,`a_inen`.
  - SUB 0010: as ADD, with `alu_sub`=1 in T5 and T6.
  - OUT 1110: T4 `a_oen`,`out_inen`; T5, T6 none.
  - HLT 1111: T4 control word all zero; next edge enters HALT.
  - Any other opcode: NOP, T4–T6 all zero.
- HALT: all controls 0, `tstate`=0, `halt`=1. Exits only through reset.
- `run`=0: state frozen and every control output forced to 0, so no register is loaded or driven while frozen. On return to `run`=1, the frozen T-state is re-issued in full.
- Bus invariant: at most one of `pc_oen`, `ram_oen`, `ir_oen`, `a_oen`, `alu_oen` is high in any cycle.

## Timing
- Outputs are Moore: combinational decode of registered state, `run` and `opcode` only; no input-to-output path except those three.
- A strobe asserted in cycle n takes effect at the rising edge ending cycle n.
- Instruction lengths: always 6 cycles, including NOPs; HLT reaches HALT after 4 cycles.
- Reset (`clr`=0 at an edge) has priority over everything, including HALT and mid-instruction states:
  - Next state T1, `tstate`=000001, `halt`=0.
  - Controls are then T1's decode, `pc_oen`=`mar_inen`=1 while `run`=1.
- `clr`=0 and `run`=0 together: state goes to T1, outputs read 0.
- `opcode` changes during T4–T6 are followed combinationally. The IR never changes there, so this case does not occur in normal operation.

## Structure
- Package `sap_ctrl_pkg` holds:
  - opcode constants `OP_LDA`, `OP_ADD`, `OP_SUB`, `OP_OUT`, `OP_HLT`;
  - one-hot T-state constants `T1`..`T6`;
  - 12-bit control-word bit indices, for benches and the top-level bus assembly.
- Sub-module `tstate_ring`: 6-bit one-hot ring with `clk`, `clr`, `run` and `stop` inputs, zero output when stopped. `sap_ctrl_seq` adds the HALT flag and the decode.

## Test plan
- Reset then `run`=1, opcode=0000 → tstate 01,02,04,08,10,20,01. Controls: T1 `pc_oen`+`mar_inen`, T2 `pc_inc`, T3 `ram_oen`+`ir_inen`, T4 `ir_oen`+`mar_inen`, T5 `ram_oen`+`a_inen`, T6 zero.
- opcode=0010 through one instruction → T5 `ram_oen`+`b_inen`+`alu_sub`; T6 `alu_oen`+`a_inen`+`alu_sub`; `alu_sub` low in all other phases.
- opcode=1110 → T4 `a_oen`+`out_inen` only. opcode=0111 → T4–T6 all zero, then back to T1.
- opcode=1111 → T4 zero; from the next cycle `halt`=1, `tstate`=0, controls stay 0 for 20 cycles. `clr`=0 for one edge → `tstate`=01, `halt`=0.
- `run`=0 for 3 cycles entering T3 → `tstate` holds 04 with all controls 0. `run`=1 → `ram_oen`+`ir_inen` then T4.
- `clr`=0 asserted in T5 of ADD → next cycle T1 with no `a_inen`. Every cycle of all scenarios checks the single-bus-driver invariant.

Source files
------------

// File: rtl/sap_ctrl_seq_pkg.sv
// Shared constants and control-word decode for the SAP-1 style sequencer.
package sap_ctrl_pkg;

    // Opcodes (IR upper nibble)
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // One-hot T-states, bit0 = T1
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // Control-word bit positions
    localparam int CW_W        = 12;
    localparam int CW_PC_INC   = 0;
    localparam int CW_PC_OEN   = 1;
    localparam int CW_MAR_INEN = 2;
    localparam int CW_RAM_OEN  = 3;
    localparam int CW_IR_INEN  = 4;
    localparam int CW_IR_OEN   = 5;
    localparam int CW_A_INEN   = 6;
    localparam int CW_A_OEN    = 7;
    localparam int CW_B_INEN   = 8;
    localparam int CW_ALU_OEN  = 9;
    localparam int CW_ALU_SUB  = 10;
    localparam int CW_OUT_INEN = 11;

    // Control word for one phase. A zero T-state (HALT) decodes to all zero.
    function automatic logic [CW_W-1:0] cw_decode(input logic [5:0] ts, input logic [3:0] op);
        logic [CW_W-1:0] cw;
        logic            mem_op;
        cw     = '0;
        mem_op = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
        case (ts)
            T1: begin
                cw[CW_PC_OEN]   = 1'b1;
                cw[CW_MAR_INEN] = 1'b1;
            end
            T2: cw[CW_PC_INC] = 1'b1;
            T3: begin
                cw[CW_RAM_OEN] = 1'b1;
                cw[CW_IR_INEN] = 1'b1;
            end
            T4: begin
                if (mem_op) begin
                    cw[CW_IR_OEN]   = 1'b1;
                    cw[CW_MAR_INEN] = 1'b1;
                end else if (op == OP_OUT) begin
                    cw[CW_A_OEN]    = 1'b1;
                    cw[CW_OUT_INEN] = 1'b1;
                end
            end
            T5: begin
                if (mem_op) cw[CW_RAM_OEN] = 1'b1;
                if (op == OP_LDA) cw[CW_A_INEN] = 1'b1;
                if (op == OP_ADD || op == OP_SUB) cw[CW_B_INEN] = 1'b1;
                if (op == OP_SUB) cw[CW_ALU_SUB] = 1'b1;
            end
            T6: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    cw[CW_ALU_OEN] = 1'b1;
                    cw[CW_A_INEN]  = 1'b1;
                end
                if (op == OP_SUB) cw[CW_ALU_SUB] = 1'b1;
            end
            default: cw = '0;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/sap_ctrl_seq_if.sv
// Sequencer-side bundle: run/opcode in, phase/halt and control strobes out.
interface sap_ctrl_seq_if;
    logic       run;
    logic [3:0] opcode;
    logic [5:0] tstate;
    logic       halt;
    logic       pc_inc, pc_oen, mar_inen, ram_oen, ir_inen, ir_oen;
    logic       a_inen, a_oen, b_inen, alu_oen, alu_sub, out_inen;

    modport master (
        input  run, opcode,
        output tstate, halt,
        output pc_inc, pc_oen, mar_inen, ram_oen, ir_inen, ir_oen,
        output a_inen, a_oen, b_inen, alu_oen, alu_sub, out_inen
    );

    modport slave (
        output run, opcode,
        input  tstate, halt,
        input  pc_inc, pc_oen, mar_inen, ram_oen, ir_inen, ir_oen,
        input  a_inen, a_oen, b_inen, alu_oen, alu_sub, out_inen
    );
endinterface

// File: rtl/sap_ctrl_seq_ring.sv
// Six-phase one-hot T-state ring; output reads zero while stopped.
module tstate_ring
    import sap_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic       stop,
    output logic [5:0] tstate
);
    logic [5:0] ring_q;

    // Rotate one phase per enabled clock; reset always lands on T1.
    always_ff @(posedge clk) begin
        if (!clr)
            ring_q <= T1;
        else if (run && !stop)
            ring_q <= {ring_q[4:0], ring_q[5]};
    end

    assign tstate = stop ? 6'b0 : ring_q;
endmodule

// File: rtl/sap_ctrl_seq.sv
// SAP controller/sequencer: T-state ring, sticky HALT, Moore control decode.
module sap_ctrl_seq
    import sap_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    sap_ctrl_seq_if.master bus
);
    logic            halt_q;
    logic [5:0]      ts;
    logic [CW_W-1:0] cw;

    tstate_ring u_ring (
        .clk    (clk),
        .clr    (clr),
        .run    (bus.run),
        .stop   (halt_q),
        .tstate (ts)
    );

    // HLT in T4 parks the sequencer; only reset releases it.
    always_ff @(posedge clk) begin
        if (!clr)
            halt_q <= 1'b0;
        else if (bus.run && ts == T4 && bus.opcode == OP_HLT)
            halt_q <= 1'b1;
    end

    // Frozen or halted cycles drive nothing onto the bus.
    always_comb begin
        cw = '0;
        if (bus.run) cw = cw_decode(ts, bus.opcode);
    end

    assign bus.tstate   = ts;
    assign bus.halt     = halt_q;
    assign bus.pc_inc   = cw[CW_PC_INC];
    assign bus.pc_oen   = cw[CW_PC_OEN];
    assign bus.mar_inen = cw[CW_MAR_INEN];
    assign bus.ram_oen  = cw[CW_RAM_OEN];
    assign bus.ir_inen  = cw[CW_IR_INEN];
    assign bus.ir_oen   = cw[CW_IR_OEN];
    assign bus.a_inen   = cw[CW_A_INEN];
    assign bus.a_oen    = cw[CW_A_OEN];
    assign bus.b_inen   = cw[CW_B_INEN];
    assign bus.alu_oen  = cw[CW_ALU_OEN];
    assign bus.alu_sub  = cw[CW_ALU_SUB];
    assign bus.out_inen = cw[CW_OUT_INEN];
endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Directed + random bench for sap_ctrl_seq against a phase-counter model.
module tb_sap_ctrl_seq;
    import sap_ctrl_pkg::*;

    logic clk = 1'b0;
    logic clr;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model state: phase 1..6 and halted flag
    int   m_phase  = 1;
    bit   m_halted = 1'b0;

    sap_ctrl_seq_if bus ();

    sap_ctrl_seq dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    logic [11:0] obs_cw;
    always_comb begin
        obs_cw = '0;
        obs_cw[CW_PC_INC]   = bus.pc_inc;
        obs_cw[CW_PC_OEN]   = bus.pc_oen;
        obs_cw[CW_MAR_INEN] = bus.mar_inen;
        obs_cw[CW_RAM_OEN]  = bus.ram_oen;
        obs_cw[CW_IR_INEN]  = bus.ir_inen;
        obs_cw[CW_IR_OEN]   = bus.ir_oen;
        obs_cw[CW_A_INEN]   = bus.a_inen;
        obs_cw[CW_A_OEN]    = bus.a_oen;
        obs_cw[CW_B_INEN]   = bus.b_inen;
        obs_cw[CW_ALU_OEN]  = bus.alu_oen;
        obs_cw[CW_ALU_SUB]  = bus.alu_sub;
        obs_cw[CW_OUT_INEN] = bus.out_inen;
    end

    // Which strobes each instruction raises in each phase.
    function automatic logic [11:0] model_cw(input int ph, input logic [3:0] op);
        logic [11:0] w;
        w = '0;
        if (ph == 1) begin w[CW_PC_OEN] = 1; w[CW_MAR_INEN] = 1; end
        if (ph == 2) w[CW_PC_INC] = 1;
        if (ph == 3) begin w[CW_RAM_OEN] = 1; w[CW_IR_INEN] = 1; end
        if (op == 4'b0000) begin
            if (ph == 4) begin w[CW_IR_OEN] = 1; w[CW_MAR_INEN] = 1; end
            if (ph == 5) begin w[CW_RAM_OEN] = 1; w[CW_A_INEN] = 1; end
        end else if (op == 4'b0001 || op == 4'b0010) begin
            if (ph == 4) begin w[CW_IR_OEN] = 1; w[CW_MAR_INEN] = 1; end
            if (ph == 5) begin w[CW_RAM_OEN] = 1; w[CW_B_INEN] = 1; end
            if (ph == 6) begin w[CW_ALU_OEN] = 1; w[CW_A_INEN] = 1; end
            if (op == 4'b0010 && ph >= 5) w[CW_ALU_SUB] = 1;
        end else if (op == 4'b1110) begin
            if (ph == 4) begin w[CW_A_OEN] = 1; w[CW_OUT_INEN] = 1; end
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, check pre-edge outputs, advance model on the edge.
    task automatic cyc(input logic c, input logic r, input logic [3:0] op);
        logic [11:0] exp_cw;
        logic [5:0]  exp_ts;
        int          drivers;
        clr        = c;
        bus.run    = r;
        bus.opcode = op;
        #1;
        exp_ts = m_halted ? 6'b0 : 6'(1 << (m_phase - 1));
        exp_cw = (r && !m_halted) ? model_cw(m_phase, op) : 12'b0;
        drivers = int'(bus.pc_oen) + int'(bus.ram_oen) + int'(bus.ir_oen)
                + int'(bus.a_oen) + int'(bus.alu_oen);
        chk("tstate", {6'b0, bus.tstate}, {6'b0, exp_ts});
        chk("halt", {11'b0, bus.halt}, {11'b0, m_halted});
        chk("ctrl", obs_cw, exp_cw);
        chk("one_driver", {11'b0, drivers <= 1}, 12'd1);
        @(posedge clk);
        if (!c) begin
            m_phase  = 1;
            m_halted = 1'b0;
        end else if (r && !m_halted) begin
            if (m_phase == 4 && op == 4'b1111) m_halted = 1'b1;
            else m_phase = (m_phase % 6) + 1;
        end
        @(negedge clk);
    endtask

    task automatic instr(input logic [3:0] op);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, op);
    endtask

    initial begin
        logic [3:0] rop;
        clr        = 1'b0;
        bus.run    = 1'b0;
        bus.opcode = 4'b0000;
        @(posedge clk);
        @(negedge clk);

        // Full instructions of each class, back to back
        instr(OP_LDA);
        instr(OP_SUB);
        instr(OP_ADD);
        instr(OP_OUT);
        instr(4'b0111);

        // HLT: four cycles, then parked for 20, then reset releases
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, OP_HLT);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, OP_HLT);
        cyc(1'b0, 1'b1, OP_HLT);
        cyc(1'b1, 1'b1, OP_LDA);

        // Freeze on entry to T3, then resume
        cyc(1'b1, 1'b1, OP_LDA);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, OP_LDA);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, OP_LDA);

        // Reset in T5 of ADD
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, OP_ADD);
        cyc(1'b0, 1'b1, OP_ADD);
        cyc(1'b1, 1'b1, OP_ADD);

        // Reset while frozen: T1, outputs quiet
        cyc(1'b0, 1'b0, OP_ADD);
        cyc(1'b1, 1'b0, OP_ADD);
        cyc(1'b1, 1'b1, OP_ADD);

        // Random run/reset/opcode; opcode chosen at instruction start
        rop = 4'(($urandom) & 32'hf);
        for (int i = 0; i < 600; i++) begin
            if (m_phase == 1 && !m_halted) rop = 4'(($urandom) & 32'hf);
            cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 5) != 0), rop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach end of stimulus");
        $fatal(1, "timeout");
    end
endmodule
